// File: rtl/sr_ctrl_pkg.sv
// ============================================================================
// Module   : sr_ctrl_pkg
// Brief    : Shared types and constants for the gated SR latch controller.
// Revision : 1.0
// ============================================================================
`default_nettype none

package sr_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_PULSE = 3'd2,
        ST_HOLD  = 3'd3,
        ST_CHECK = 3'd4,
        ST_CLR   = 3'd5
    } state_t;

    localparam logic OP_SET = 1'b1;
    localparam logic OP_CLR = 1'b0;

    function automatic int sr_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sr_latch_arb_ctrl_rr_arbiter.sv
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin arbiter: first set request at or after
//            the pointer, wrapping; returns a one-hot grant and its index.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [PW-1:0] o_idx,
    output logic          o_any
);

    localparam logic [PW:0] c_N = (PW + 1)'(N);

    logic [PW:0] w_pos;

    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        w_pos = '0;
        for (int i = 0; i < N; i++) begin
            // Pointer plus offset stays below 2N, so one subtraction wraps it.
            w_pos = {1'b0, i_ptr} + (PW + 1)'(i);
            if (w_pos >= c_N) begin
                w_pos = w_pos - c_N;
            end
            if (!o_any && i_req[w_pos[PW-1:0]]) begin
                o_any = 1'b1;
                o_idx = w_pos[PW-1:0];
            end
        end
        o_gnt[o_idx] = o_any;
    end

endmodule

`default_nettype wire

// File: rtl/sr_latch_arb_ctrl.sv
// ============================================================================
// Module   : sr_latch_arb_ctrl
// Brief    : Round-robin sequencer driving one shared gated SR latch through
//            SETUP / enable-pulse / HOLD / CHECK, plus a global latch clear.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sr_latch_arb_ctrl
    import sr_ctrl_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] req_op,
    input  logic               clr_all,
    output logic [NUM_REQ-1:0] gnt,
    output logic               done,
    output logic               busy,
    output logic               err,
    output logic               latch_S,
    output logic               latch_R,
    output logic               latch_en,
    output logic               latch_reset,
    input  logic               latch_Q,
    input  logic               latch_Q_n
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(sr_max(SETUP_CYC, PULSE_CYC) + 1);

    localparam logic [CW-1:0] c_SETUP = CW'(SETUP_CYC);
    localparam logic [CW-1:0] c_PULSE = CW'(PULSE_CYC);
    localparam logic [CW-1:0] c_ONE   = CW'(1);
    localparam logic [PW-1:0] c_LAST  = PW'(NUM_REQ - 1);

    state_t             r_state, w_nxt_state;
    logic [CW-1:0]      r_cnt, w_nxt_cnt;
    logic [PW-1:0]      r_ptr, w_nxt_ptr;
    logic               r_exp, w_nxt_exp;
    logic [NUM_REQ-1:0] r_gnt, w_nxt_gnt;
    logic               r_err, w_nxt_err;
    logic               r_clr_pend, w_nxt_clr_pend;
    logic               r_done, w_nxt_done;
    logic               r_busy, w_nxt_busy;
    logic               r_S, w_nxt_S;
    logic               r_R, w_nxt_R;
    logic               r_en, w_nxt_en;
    logic               r_lrst, w_nxt_lrst;

    logic [NUM_REQ-1:0] w_arb_gnt;
    logic [PW-1:0]      w_win;
    logic               w_any;

    rr_arbiter #(
        .N  (NUM_REQ),
        .PW (PW)
    ) u_arb (
        .i_req (req),
        .i_ptr (r_ptr),
        .o_gnt (w_arb_gnt),
        .o_idx (w_win),
        .o_any (w_any)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_ptr      <= '0;
            r_exp      <= 1'b0;
            r_gnt      <= '0;
            r_err      <= 1'b0;
            r_clr_pend <= 1'b0;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
            r_S        <= 1'b0;
            r_R        <= 1'b0;
            r_en       <= 1'b0;
            r_lrst     <= 1'b0;
        end else begin
            r_state    <= w_nxt_state;
            r_cnt      <= w_nxt_cnt;
            r_ptr      <= w_nxt_ptr;
            r_exp      <= w_nxt_exp;
            r_gnt      <= w_nxt_gnt;
            r_err      <= w_nxt_err;
            r_clr_pend <= w_nxt_clr_pend;
            r_done     <= w_nxt_done;
            r_busy     <= w_nxt_busy;
            r_S        <= w_nxt_S;
            r_R        <= w_nxt_R;
            r_en       <= w_nxt_en;
            r_lrst     <= w_nxt_lrst;
        end
    end

    always_comb begin
        w_nxt_state    = r_state;
        w_nxt_cnt      = r_cnt;
        w_nxt_ptr      = r_ptr;
        w_nxt_exp      = r_exp;
        w_nxt_gnt      = r_gnt;
        w_nxt_err      = r_err;
        // A clear arriving mid-sequence is remembered for the next IDLE.
        w_nxt_clr_pend = r_clr_pend |
                         (clr_all & (r_state != ST_IDLE) & (r_state != ST_CLR));

        case (r_state)
            ST_IDLE: begin
                if (clr_all || r_clr_pend) begin
                    w_nxt_state    = ST_CLR;
                    w_nxt_cnt      = c_PULSE;
                    w_nxt_clr_pend = 1'b0;
                end else if (w_any) begin
                    w_nxt_state = ST_SETUP;
                    w_nxt_cnt   = c_SETUP;
                    w_nxt_gnt   = w_arb_gnt;
                    w_nxt_exp   = req_op[w_win];
                    w_nxt_ptr   = (w_win == c_LAST) ? '0 : w_win + 1'b1;
                end
            end
            ST_SETUP: begin
                if (r_cnt == c_ONE) begin
                    w_nxt_state = ST_PULSE;
                    w_nxt_cnt   = c_PULSE;
                end else begin
                    w_nxt_cnt = r_cnt - c_ONE;
                end
            end
            ST_PULSE: begin
                if (r_cnt == c_ONE) begin
                    w_nxt_state = ST_HOLD;
                    w_nxt_cnt   = '0;
                end else begin
                    w_nxt_cnt = r_cnt - c_ONE;
                end
            end
            ST_HOLD: begin
                // Latch has settled by HOLD, so err is valid alongside done.
                w_nxt_state = ST_CHECK;
                if ((latch_Q != r_exp) || (latch_Q == latch_Q_n)) begin
                    w_nxt_err = 1'b1;
                end
            end
            ST_CHECK: begin
                w_nxt_state = ST_IDLE;
                w_nxt_gnt   = '0;
            end
            ST_CLR: begin
                if (r_cnt == c_ONE) begin
                    w_nxt_state = ST_IDLE;
                    w_nxt_cnt   = '0;
                end else begin
                    w_nxt_cnt = r_cnt - c_ONE;
                end
            end
            default: begin
                w_nxt_state = ST_IDLE;
                w_nxt_cnt   = '0;
                w_nxt_gnt   = '0;
            end
        endcase

        // Pin values are decoded from the next state so every output is a flop.
        w_nxt_S    = ((w_nxt_state == ST_SETUP) || (w_nxt_state == ST_PULSE)) &&
                     (w_nxt_exp == OP_SET);
        w_nxt_R    = ((w_nxt_state == ST_SETUP) || (w_nxt_state == ST_PULSE)) &&
                     (w_nxt_exp == OP_CLR);
        w_nxt_en   = (w_nxt_state == ST_PULSE);
        w_nxt_lrst = (w_nxt_state == ST_CLR);
        w_nxt_done = (w_nxt_state == ST_CHECK) ||
                     ((w_nxt_state == ST_CLR) && (w_nxt_cnt == c_ONE));
        w_nxt_busy = (w_nxt_state != ST_IDLE);
    end

    assign gnt         = r_gnt;
    assign done        = r_done;
    assign busy        = r_busy;
    assign err         = r_err;
    assign latch_S     = r_S;
    assign latch_R     = r_R;
    assign latch_en    = r_en;
    assign latch_reset = r_lrst;

endmodule

`default_nettype wire

// File: tb/tb_sr_latch_arb_ctrl.sv
// ============================================================================
// Module   : tb_sr_latch_arb_ctrl
// Brief    : Scoreboard bench for sr_latch_arb_ctrl driving a gated SR latch.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_sr_latch_arb_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] req;
    logic [3:0] req_op;
    logic       clr_all;
    logic [3:0] gnt;
    logic       done;
    logic       busy;
    logic       err;
    logic       latch_S;
    logic       latch_R;
    logic       latch_en;
    logic       latch_reset;
    logic       latch_Q;
    logic       latch_Q_n;

    logic       stuck;
    logic       lq;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Gated SR latch load; stuck forces the Q pin low.
    always_latch begin
        if (latch_reset) begin
            lq <= 1'b0;
        end else if (latch_en && (latch_S ^ latch_R)) begin
            lq <= latch_S;
        end
    end
    assign latch_Q   = stuck ? 1'b0 : lq;
    assign latch_Q_n = ~lq;

    sr_latch_arb_ctrl #(
        .NUM_REQ   (4),
        .SETUP_CYC (1),
        .PULSE_CYC (2)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req         (req),
        .req_op      (req_op),
        .clr_all     (clr_all),
        .gnt         (gnt),
        .done        (done),
        .busy        (busy),
        .err         (err),
        .latch_S     (latch_S),
        .latch_R     (latch_R),
        .latch_en    (latch_en),
        .latch_reset (latch_reset),
        .latch_Q     (latch_Q),
        .latch_Q_n   (latch_Q_n)
    );

    typedef struct {
        logic [3:0] gnt;
        logic       q;
        logic       err;
        logic       op;
        int         due;
    } exp_t;

    exp_t sbq[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_chk++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp_v, cyc);
        end
    endtask

    task automatic expect_done(input logic [3:0] g, input logic q, input logic e,
                               input logic op, input int due);
        exp_t x;
        x.gnt = g;
        x.q   = q;
        x.err = e;
        x.op  = op;
        x.due = due;
        sbq.push_back(x);
    endtask

    task automatic run_until(input int k, input bit drop, input int budget);
        int seen = 0;
        int t    = 0;
        while (seen < k && t < budget) begin
            @(negedge clk);
            t++;
            if (done) begin
                seen++;
                if (drop) req = req & ~gnt;
            end
        end
        if (seen < k) begin
            n_chk++;
            n_fail++;
            $display("FAIL run_until_timeout: got %0d dones expected %0d", seen, k);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_outputs", {gnt, done, busy, err, latch_S, latch_R, latch_en, latch_reset}, 0);
        reset_n = 1'b1;
    endtask

    // Monitor: invariants every cycle, scoreboard pop on every done.
    logic       m_p_en  = 1'b0;
    logic [1:0] m_p_sr  = 2'b00;
    logic [1:0] m_sr    = 2'b00;
    int         m_enlen = 0;
    int         m_rslen = 0;
    exp_t       m_e;

    initial begin
        forever begin
            @(negedge clk);
            chk("inv_s_and_r", latch_S & latch_R, 0);
            chk("inv_en_and_reset", latch_en & latch_reset, 0);
            chk("inv_gnt_onehot0", $onehot0(gnt), 1);
            if (latch_en && m_p_en) chk("inv_sr_stable", {latch_S, latch_R}, m_p_sr);
            if (!busy) begin
                m_enlen = 0;
                m_rslen = 0;
                m_sr    = 2'b00;
            end
            if (latch_en) begin
                m_enlen++;
                m_sr = {latch_S, latch_R};
            end
            if (latch_reset) m_rslen++;
            if (done) begin
                if (sbq.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL sb_unexpected_done: got done gnt=%0h expected no done", gnt);
                end else begin
                    m_e = sbq.pop_front();
                    chk("sb_gnt", gnt, m_e.gnt);
                    chk("sb_latch_q", latch_Q, m_e.q);
                    chk("sb_err", err, m_e.err);
                    chk("sb_done_cycle", cyc, m_e.due);
                    chk("sb_en_len", m_enlen, (m_e.gnt != 0) ? 2 : 0);
                    chk("sb_reset_len", m_rslen, (m_e.gnt != 0) ? 0 : 2);
                    if (m_e.gnt != 0) chk("sb_sr_pulse", m_sr, {m_e.op, ~m_e.op});
                end
                m_enlen = 0;
                m_rslen = 0;
                m_sr    = 2'b00;
            end
            m_p_en = latch_en;
            m_p_sr = {latch_S, latch_R};
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        req     = '0;
        req_op  = '0;
        clr_all = 1'b0;
        stuck   = 1'b0;
        do_reset();

        // 1: single set by requester 0
        req = 4'b0001; req_op = 4'b0001;
        expect_done(4'b0001, 1'b1, 1'b0, 1'b1, cyc + 5);
        run_until(1, 1'b1, 40);

        // 2: requester 2 clears Q
        @(negedge clk);
        req = 4'b0100; req_op = 4'b0000;
        expect_done(4'b0100, 1'b0, 1'b0, 1'b0, cyc + 5);
        run_until(1, 1'b1, 40);

        // 3: all requesting continuously from rr pointer 0
        do_reset();
        req = 4'b1111; req_op = 4'b0101;
        expect_done(4'b0001, 1'b1, 1'b0, 1'b1, cyc + 5);
        expect_done(4'b0010, 1'b0, 1'b0, 1'b0, cyc + 11);
        expect_done(4'b0100, 1'b1, 1'b0, 1'b1, cyc + 17);
        expect_done(4'b1000, 1'b0, 1'b0, 1'b0, cyc + 23);
        expect_done(4'b0001, 1'b1, 1'b0, 1'b1, cyc + 29);
        run_until(5, 1'b0, 80);
        req = '0;

        // 4: clr_all mid-PULSE of requester 2, requester 3 pending (pointer is 1)
        @(negedge clk);
        req = 4'b1100; req_op = 4'b1100;
        expect_done(4'b0100, 1'b1, 1'b0, 1'b1, cyc + 5);
        expect_done(4'b0000, 1'b0, 1'b0, 1'b0, cyc + 8);
        expect_done(4'b1000, 1'b1, 1'b0, 1'b1, cyc + 14);
        repeat (2) @(negedge clk);
        clr_all = 1'b1;
        @(negedge clk);
        clr_all = 1'b0;
        run_until(3, 1'b1, 60);

        // 5: asynchronous reset during PULSE, then pointer back at 0
        @(negedge clk);
        req = 4'b0010; req_op = 4'b0010;
        repeat (2) @(negedge clk);
        chk("t5_en_in_pulse", latch_en, 1);
        reset_n = 1'b0;
        #1;
        chk("t5_async_reset_outputs",
            {gnt, done, busy, err, latch_S, latch_R, latch_en, latch_reset}, 0);
        @(negedge clk);
        reset_n = 1'b1;
        req = 4'b1111; req_op = 4'b0000;
        expect_done(4'b0001, 1'b0, 1'b0, 1'b0, cyc + 5);
        run_until(1, 1'b1, 40);
        req = '0;

        // 6: stuck Q gives sticky err until reset_n
        @(negedge clk);
        stuck = 1'b1;
        req = 4'b0001; req_op = 4'b0001;
        expect_done(4'b0001, 1'b0, 1'b1, 1'b1, cyc + 5);
        run_until(1, 1'b1, 40);
        stuck = 1'b0;
        @(negedge clk);
        req = 4'b0010; req_op = 4'b0000;
        expect_done(4'b0010, 1'b0, 1'b1, 1'b0, cyc + 5);
        run_until(1, 1'b1, 40);
        @(negedge clk);
        chk("t6_err_sticky", err, 1);
        do_reset();

        repeat (2) @(negedge clk);
        chk("sb_drained", sbq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
